// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external 64-bit combinational ALU between
// the execute stage (requester 0) and the address/branch-target unit (requester 1).
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_z,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_flag,
    output logic             resp_id,
    output logic             resp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg;
    logic             id_reg;
    logic             illegal_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [3:0]       alu_ctrl_reg;
    logic [WIDTH-1:0] resp_data_reg;
    logic             resp_flag_reg, resp_id_reg, resp_err_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic [1:0]       valid_vec, grant_vec, ready_vec;
    logic [WIDTH-1:0] a_vec [2];
    logic [WIDTH-1:0] b_vec [2];
    logic [3:0]       ctrl_vec [2];
    logic             accept, sel;
    logic [3:0]       ctrl_sel;
    logic             ctrl_legal;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign valid_vec   = {req1_valid, req0_valid};
    assign a_vec[0]    = req0_a;
    assign a_vec[1]    = req1_a;
    assign b_vec[0]    = req0_b;
    assign b_vec[1]    = req1_b;
    assign ctrl_vec[0] = req0_ctrl;
    assign ctrl_vec[1] = req1_ctrl;

    // A requester wins when it is alone, or on a conflict when it was not granted last.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign grant_vec[gi] = valid_vec[gi] &&
                                   (!valid_vec[1-gi] || (last_grant_reg != 1'(gi)));
            assign ready_vec[gi] = (state_reg == IDLE) && grant_vec[gi] && !rst;
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |(valid_vec & ready_vec);
    assign sel        = ready_vec[1];
    assign ctrl_sel   = ctrl_vec[sel];
    assign ctrl_legal = is_legal(ctrl_sel);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            illegal_reg    <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= 4'b0000;
            resp_data_reg  <= '0;
            resp_flag_reg  <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                alu_a_reg      <= a_vec[sel];
                alu_b_reg      <= b_vec[sel];
                // Illegal codes are replaced at latch time so the ALU never sees them.
                alu_ctrl_reg   <= ctrl_legal ? ctrl_sel : 4'b0000;
                illegal_reg    <= !ctrl_legal;
                id_reg         <= sel;
                last_grant_reg <= sel;
            end
            if (state_reg == EXEC) begin
                resp_data_reg <= illegal_reg ? '0 : alu_res;
                resp_flag_reg <= illegal_reg ? 1'b0 : alu_z;
                resp_err_reg  <= illegal_reg;
                resp_id_reg   <= id_reg;
            end
            if (state_reg == RESP && resp_ready) begin
                op_count_reg <= op_count_reg + CNT_W'(1);
            end
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_ctrl   = alu_ctrl_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = resp_data_reg;
    assign resp_flag  = resp_flag_reg;
    assign resp_id    = resp_id_reg;
    assign resp_err   = resp_err_reg;
    assign busy       = (state_reg != IDLE);
    assign op_count   = op_count_reg;

endmodule
